// File: rtl/delayed_regread_arbiter_if.sv
// Operand-read bus between the delayed-execution lanes, the register file
// read/write ports and the read-port arbiter.
interface delayed_regread_arbiter_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned RPORTS = 2,
  parameter int unsigned WPORTS = 2
);
  logic                           flush;
  logic [LANES-1:0]               lane_valid;
  logic [LANES-1:0][4:0]          lane_rs1;
  logic [LANES-1:0][4:0]          lane_rs2;
  logic [LANES-1:0]               lane_use_imm;
  logic [RPORTS-1:0][4:0]         rf_raddr;
  logic [RPORTS-1:0][31:0]        rf_rdata;
  logic [WPORTS-1:0]              rf_we;
  logic [WPORTS-1:0][4:0]         rf_waddr;
  logic [WPORTS-1:0][31:0]        rf_wdata;
  logic [LANES-1:0][1:0][31:0]    lane_rdata;
  logic                           stall;

  // Pipeline plus register file side.
  modport master (
    output flush, lane_valid, lane_rs1, lane_rs2, lane_use_imm,
    output rf_rdata, rf_we, rf_waddr, rf_wdata,
    input  rf_raddr, lane_rdata, stall
  );

  // Arbiter side.
  modport slave (
    input  flush, lane_valid, lane_rs1, lane_rs2, lane_use_imm,
    input  rf_rdata, rf_we, rf_waddr, rf_wdata,
    output rf_raddr, lane_rdata, stall
  );
endinterface

// File: rtl/delayed_regread_arbiter.sv
// Shares RPORTS register file read ports among the delayed-execution lanes,
// splitting an over-subscribed operand group across two cycles with one stall.
module delayed_regread_arbiter #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned RPORTS = 2,
  parameter int unsigned WPORTS = 2
) (
  input logic                       clk,
  input logic                       rst,
  delayed_regread_arbiter_if.slave  bus
);

  localparam int unsigned NREQ  = 2 * LANES;
  localparam int unsigned DEPTH = NREQ + RPORTS;

  localparam logic [0:0] ST_ONE = 1'b0;
  localparam logic [0:0] ST_TWO = 1'b1;

  logic [0:0]               state;
  logic [RPORTS-1:0]        cap_valid;
  logic [RPORTS-1:0][4:0]   cap_addr;
  logic [RPORTS-1:0][31:0]  cap_data;

  logic [NREQ-1:0]          req_need;
  logic [NREQ-1:0][4:0]     req_addr;
  logic [DEPTH-1:0][4:0]    dist_addr;
  int unsigned              dist_cnt;
  logic                     found;
  logic                     split;
  logic [RPORTS-1:0][4:0]   raddr;
  logic [RPORTS-1:0][31:0]  cap_next;
  logic [RPORTS-1:0][31:0]  cap_view;
  logic [LANES-1:0][1:0][31:0] rdata;
  logic [31:0]              opnd;

  // Highest-numbered matching write port wins; address 0 never matches.
  function automatic logic [31:0] snoop(
    input logic [4:0]               a,
    input logic [31:0]              base,
    input logic [WPORTS-1:0]        we,
    input logic [WPORTS-1:0][4:0]   wa,
    input logic [WPORTS-1:0][31:0]  wd
  );
    logic [31:0] r;
    r = base;
    for (int unsigned k = 0; k < WPORTS; k++)
      if (we[k] && wa[k] != '0 && wa[k] == a) r = wd[k];
    return r;
  endfunction

  always_comb begin
    req_need  = '0;
    req_addr  = '0;
    dist_addr = '0;
    dist_cnt  = 0;
    found     = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      req_addr[2*l]   = bus.lane_rs1[l];
      req_addr[2*l+1] = bus.lane_rs2[l];
      req_need[2*l]   = bus.lane_valid[l] && bus.lane_rs1[l] != '0;
      req_need[2*l+1] = bus.lane_valid[l] && !bus.lane_use_imm[l] && bus.lane_rs2[l] != '0;
    end
    // Build the distinct-address list in first-appearance priority order.
    for (int unsigned i = 0; i < NREQ; i++) begin
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++)
        if (k < dist_cnt && dist_addr[k] == req_addr[i]) found = 1'b1;
      if (req_need[i] && !found) begin
        dist_addr[dist_cnt] = req_addr[i];
        dist_cnt = dist_cnt + 1;
      end
    end
    split = (dist_cnt > RPORTS);

    raddr = '0;
    for (int unsigned p = 0; p < RPORTS; p++) begin
      if (state == ST_ONE) begin
        if (p < dist_cnt) raddr[p] = dist_addr[p];
      end else begin
        if (RPORTS + p < dist_cnt) raddr[p] = dist_addr[RPORTS+p];
      end
    end

    cap_next = '0;
    cap_view = '0;
    for (int unsigned p = 0; p < RPORTS; p++) begin
      cap_next[p] = snoop(raddr[p], bus.rf_rdata[p], bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      cap_view[p] = snoop(cap_addr[p], cap_data[p], bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
  end

  // Operands resolve by address: live ports first, then valid capture slots.
  always_comb begin
    rdata = '0;
    opnd  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned o = 0; o < 2; o++) begin
        opnd = '0;
        if (req_need[2*l+o]) begin
          for (int unsigned p = 0; p < RPORTS; p++)
            if (raddr[p] == req_addr[2*l+o]) opnd = bus.rf_rdata[p];
          for (int unsigned p = 0; p < RPORTS; p++)
            if (cap_valid[p] && cap_addr[p] == req_addr[2*l+o]) opnd = cap_view[p];
        end
        rdata[l][o] = opnd;
      end
    end
  end

  assign bus.rf_raddr   = raddr;
  assign bus.lane_rdata = rdata;
  assign bus.stall      = (state == ST_ONE) && split && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ONE;
      cap_valid <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
    end else if (bus.flush) begin
      state     <= ST_ONE;
      cap_valid <= '0;
    end else if (state == ST_ONE) begin
      if (split) begin
        state     <= ST_TWO;
        cap_valid <= '1;
        cap_addr  <= raddr;
        cap_data  <= cap_next;
      end
    end else begin
      state     <= ST_ONE;
      cap_valid <= '0;
    end
  end

endmodule

// File: tb/tb_delayed_regread_arbiter.sv
// Directed bench: stimulus pushes hand-computed operand sets to a scoreboard
// queue; a negedge monitor pops and compares whenever a group completes.
module tb_delayed_regread_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delayed_regread_arbiter_if #(.LANES(2), .RPORTS(2), .WPORTS(2)) bus ();

  delayed_regread_arbiter #(.LANES(2), .RPORTS(2), .WPORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [32];
  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign bus.rf_rdata[p] = mem[bus.rf_raddr[p]];
  end

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected operands in lane order: L0.rs1, L0.rs2, L1.rs1, L1.rs2.
  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    exp_q.push_back({d, c, b, a});
  endtask

  task automatic set_lanes(input logic v0, input logic [4:0] a0, input logic [4:0] b0, input logic i0,
                           input logic v1, input logic [4:0] a1, input logic [4:0] b1, input logic i1);
    bus.lane_valid   = {v1, v0};
    bus.lane_rs1     = {a1, a0};
    bus.lane_rs2     = {b1, b0};
    bus.lane_use_imm = {i1, i0};
  endtask

  // Advance one clock; writes presented in the previous cycle land in the model.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      if (bus.rf_we[k] && bus.rf_waddr[k] != 5'd0) mem[bus.rf_waddr[k]] = bus.rf_wdata[k];
    bus.rf_we = '0;
  endtask

  task automatic chk_port(input string name, input logic st, input logic [4:0] r0, input logic [4:0] r1);
    chk({name, "_stall"}, 128'(bus.stall), 128'(st));
    chk({name, "_raddr"}, 128'(bus.rf_raddr), 128'({r1, r0}));
  endtask

  initial begin : monitor
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (!rst && !bus.flush && !bus.stall && bus.lane_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", bus.lane_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("lane_rdata", 128'(bus.lane_rdata), e);
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 32; i++) mem[i] = 32'(i * 16);
    mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'hA5; mem[4] = 32'h44;
    mem[9] = 32'h99; mem[10] = 32'hAA;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.rf_we = '0; bus.rf_waddr = '0; bus.rf_wdata = '0;
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #2;
    chk_port("reset", 1'b0, 5'd0, 5'd0);
    chk("reset_rdata", 128'(bus.lane_rdata), 128'd0);

    // Single-cycle group, all reads collapse onto r3.
    next_cycle();
    set_lanes(1, 5'd3, 5'd3, 0, 1, 5'd3, 5'd0, 0);
    push(32'hA5, 32'hA5, 32'hA5, 32'h0);
    #2; chk_port("single", 1'b0, 5'd3, 5'd0);

    // L0.rs2 is an immediate, so 1,4,1 dedupe to two reads with no split.
    next_cycle();
    set_lanes(1, 5'd1, 5'd2, 1, 1, 5'd4, 5'd1, 0);
    push(32'h11, 32'h0, 32'h44, 32'h11);
    #2; chk_port("imm", 1'b0, 5'd1, 5'd4);

    // Four distinct reads split over two cycles.
    next_cycle();
    set_lanes(1, 5'd5, 5'd6, 0, 1, 5'd7, 5'd8, 0);
    push(32'h50, 32'h60, 32'h70, 32'h80);
    #2; chk_port("split_c1", 1'b1, 5'd5, 5'd6);
    next_cycle();
    #2; chk_port("split_c2", 1'b0, 5'd7, 5'd8);

    // Write to r6 at the capture edge must land in the captured slot.
    next_cycle();
    set_lanes(1, 5'd5, 5'd6, 0, 1, 5'd7, 5'd8, 0);
    bus.rf_we = 2'b10; bus.rf_waddr[1] = 5'd6; bus.rf_wdata[1] = 32'hDEAD;
    push(32'h50, 32'hDEAD, 32'h70, 32'h80);
    #2; chk_port("coh_c1", 1'b1, 5'd5, 5'd6);
    next_cycle();
    #2; chk_port("coh_c2", 1'b0, 5'd7, 5'd8);
    mem[6] = 32'h60;

    // Two writes to r5 during the second cycle: higher port wins.
    next_cycle();
    set_lanes(1, 5'd5, 5'd6, 0, 1, 5'd7, 5'd8, 0);
    push(32'hCAFE, 32'h60, 32'h70, 32'h80);
    #2; chk_port("wtwo_c1", 1'b1, 5'd5, 5'd6);
    next_cycle();
    bus.rf_we = 2'b11;
    bus.rf_waddr[0] = 5'd5; bus.rf_wdata[0] = 32'hBEEF;
    bus.rf_waddr[1] = 5'd5; bus.rf_wdata[1] = 32'hCAFE;
    #2; chk_port("wtwo_c2", 1'b0, 5'd7, 5'd8);
    next_cycle();
    mem[5] = 32'h50;

    // Flush abandons the split; next group runs single-cycle.
    set_lanes(1, 5'd5, 5'd6, 0, 1, 5'd7, 5'd8, 0);
    bus.flush = 1'b1;
    #2; chk_port("flush_c1", 1'b0, 5'd5, 5'd6);
    next_cycle();
    bus.flush = 1'b0;
    set_lanes(1, 5'd9, 5'd10, 0, 0, 5'd0, 5'd0, 0);
    push(32'h99, 32'hAA, 32'h0, 32'h0);
    #2; chk_port("flush_next", 1'b0, 5'd9, 5'd10);

    // Reset lands in the second cycle of a split.
    next_cycle();
    set_lanes(1, 5'd5, 5'd6, 0, 1, 5'd7, 5'd8, 0);
    #2; chk_port("rsplit_c1", 1'b1, 5'd5, 5'd6);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_lanes(1, 5'd3, 5'd5, 0, 1, 5'd5, 5'd0, 0);
    push(32'hA5, 32'h50, 32'h50, 32'h0);
    #2; chk_port("rsplit_next", 1'b0, 5'd3, 5'd5);

    // No valid lanes: zero addresses and operands.
    next_cycle();
    set_lanes(0, 5'd7, 5'd8, 0, 0, 5'd9, 5'd1, 0);
    #2;
    chk_port("idle", 1'b0, 5'd0, 5'd0);
    chk("idle_rdata", 128'(bus.lane_rdata), 128'd0);

    next_cycle();
    next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
